fft_frame_buffer: RTL

- Ping-pong input frame buffer directly upstream of the combinational 32-point radix-2 butterfly array.
- Accepts real time-domain samples as a valid/ready stream and assembles them into N-sample frames.
- Presents each complete frame as one flat bus with a frame handshake, replacing the static ROM-loaded sample array as the butterfly input.
- Two banks, so a new frame fills while the previous one is held for the butterfly.

---
 rtl/fft_frame_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fft_frame_buffer.sv
// Two-bank ping-pong frame assembler feeding the 32-point butterfly array with one flat frame bus.
// Define FFT_FRAME_BUFFER_BITREV_EN to present slots in bit-reversed (decimation-in-time) order.
module fft_frame_buffer #(
  parameter int N  = 32,
  parameter int DW = 32,
  parameter int IW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_sof,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [N*DW-1:0] frame_data,
  output logic            sync_err,
  output logic [7:0]      frame_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_e;

  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  bank_st_e        st_r     [2];
  bank_st_e        st_nxt_s [2];
  logic [DW-1:0]   mem_r    [2][N];
  logic            wr_bank_r;
  logic            rd_bank_r;
  logic            live_r;
  logic [IW-1:0]   wr_idx_r;
  logic            sync_err_r;
  logic [7:0]      frame_cnt_r;

  logic            in_ready_s;
  logic            frame_valid_s;
  logic [N*DW-1:0] frame_data_s;
  logic            wr_acc_s;
  logic            rd_acc_s;
  logic            resync_s;
  logic            wr_last_s;
  logic [IW-1:0]   wr_addr_s;

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) begin
      r[i] = v[IW-1-i];
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] slot_map(input int k);
    logic [IW-1:0] kk;
    kk = IW'(k);
`ifdef FFT_FRAME_BUFFER_BITREV_EN
    return bitrev(kk);
`else
    return kk;
`endif
  endfunction

  // Handshake qualification; an in_sof mid-frame restarts the frame at slot 0.
  always_comb begin
    wr_acc_s  = in_valid & in_ready_s;
    rd_acc_s  = frame_valid_s & frame_ready;
    resync_s  = wr_acc_s & in_sof & (wr_idx_r != IDX_ZERO);
    wr_last_s = wr_acc_s & ~resync_s & (wr_idx_r == IDX_LAST);
    if (resync_s) begin
      wr_addr_s = IDX_ZERO;
    end else begin
      wr_addr_s = wr_idx_r;
    end
  end

  // Bank state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r[0] <= EMPTY;
      st_r[1] <= EMPTY;
    end else begin
      st_r[0] <= st_nxt_s[0];
      st_r[1] <= st_nxt_s[1];
    end
  end

  // Per-bank next state; writer and reader never own the same bank in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_nxt_s[b] = st_r[b];
      case (st_r[b])
        EMPTY: begin
          if (wr_acc_s && (wr_bank_r == 1'(b))) begin
            st_nxt_s[b] = wr_last_s ? FULL : FILLING;
          end else begin
            st_nxt_s[b] = EMPTY;
          end
        end
        FILLING: begin
          if (wr_last_s && (wr_bank_r == 1'(b))) begin
            st_nxt_s[b] = FULL;
          end else begin
            st_nxt_s[b] = FILLING;
          end
        end
        FULL: begin
          if (rd_acc_s && (rd_bank_r == 1'(b))) begin
            st_nxt_s[b] = EMPTY;
          end else begin
            st_nxt_s[b] = FULL;
          end
        end
        default: st_nxt_s[b] = EMPTY;
      endcase
    end
  end

  // Output decode from registered state; frame bus is zeroed whenever no frame is presented.
  always_comb begin
    in_ready_s    = live_r & (st_r[wr_bank_r] != FULL);
    frame_valid_s = (st_r[rd_bank_r] == FULL);
    frame_data_s  = {(N*DW){1'b0}};
    for (int k = 0; k < N; k++) begin
      if (frame_valid_s) begin
        frame_data_s[k*DW +: DW] = mem_r[rd_bank_r][slot_map(k)];
      end else begin
        frame_data_s[k*DW +: DW] = {DW{1'b0}};
      end
    end
  end

  // Write pointers, read pointer, frame counter and sync error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_r      <= 1'b0;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_idx_r    <= IDX_ZERO;
      sync_err_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      live_r     <= 1'b1;
      sync_err_r <= resync_s;
      if (resync_s) begin
        wr_idx_r <= IDX_ONE;
      end else if (wr_last_s) begin
        wr_idx_r  <= IDX_ZERO;
        wr_bank_r <= ~wr_bank_r;
      end else if (wr_acc_s) begin
        wr_idx_r <= wr_idx_r + IDX_ONE;
      end
      if (rd_acc_s) begin
        rd_bank_r   <= ~rd_bank_r;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
    end
  end

  // Sample storage; contents are qualified by bank state so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_bank_r][wr_addr_s] <= in_data;
    end
  end

  assign in_ready    = in_ready_s;
  assign frame_valid = frame_valid_s;
  assign frame_data  = frame_data_s;
  assign sync_err    = sync_err_r;
  assign frame_cnt   = frame_cnt_r;

endmodule
